// File: rtl/uart_rx_fifo.sv
// ============================================================================
// uart_rx_fifo: mid-bit sampling serial receiver with show-ahead receive FIFO.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int CLK_PER_BIT = 434,
    parameter int DATA_WIDTH  = 8,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_WIDTH  = 4
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD  = 1'b0
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  busy,
    output logic                  framing_error,
    output logic                  overrun_error,
    output logic                  parity_error
);

    localparam int                  DIV_W      = $clog2(CLK_PER_BIT);
    localparam int                  IDX_W      = 4;
    localparam logic [DIV_W-1:0]    DIV_FULL   = DIV_W'(CLK_PER_BIT - 1);
    localparam logic [DIV_W-1:0]    DIV_HALF   = DIV_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0]    DATA_LAST  = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0]    STOP_LAST  = IDX_W'(STOP_BITS - 1);
    localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, sync2_q;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    stop_bad_q, stop_bad_d;
    logic                    push_q, push_d;
    logic                    fe_q, fe_d;
    logic                    pe_q, pe_d;
    logic                    ov_q;
    logic                    w_line;
    logic                    w_tick;
    logic                    w_par_bad;
    logic                    w_stop_bad;

    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]     count_q;
    logic                    w_valid;
    logic                    w_full;
    logic                    w_do_pop;
    logic                    w_do_push;

    assign w_line     = sync2_q;
    assign w_tick     = (div_q == '0);
    assign w_stop_bad = stop_bad_q | ~w_line;

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    assign w_par_bad = par_bad_q;
`else
    assign w_par_bad = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        idx_d      = idx_q;
        data_d     = data_q;
        stop_bad_d = stop_bad_q;
        push_d     = 1'b0;
        fe_d       = 1'b0;
        pe_d       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!w_line) begin
                    state_d = S_START;
                    div_d   = DIV_HALF;
                end
            end
            S_START: begin
                if (!w_tick) begin
                    div_d = div_q - 1'b1;
                end else if (w_line) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DATA;
                    div_d   = DIV_FULL;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (!w_tick) begin
                    div_d = div_q - 1'b1;
                end else begin
                    // LSB arrives first, so after DATA_WIDTH shifts it sits in bit 0
                    data_d = {w_line, data_q[DATA_WIDTH-1:1]};
                    div_d  = DIV_FULL;
                    if (idx_q == DATA_LAST) begin
                        idx_d      = '0;
                        stop_bad_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                        state_d    = S_PARITY;
`else
                        state_d    = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (!w_tick) begin
                    div_d = div_q - 1'b1;
                end else begin
                    par_bad_d = (^data_q) ^ w_line ^ PARITY_ODD;
                    div_d     = DIV_FULL;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (!w_tick) begin
                    div_d = div_q - 1'b1;
                end else begin
                    div_d = DIV_FULL;
                    if (idx_q == STOP_LAST) begin
                        fe_d = w_stop_bad;
                        pe_d = w_par_bad;
                        if (w_stop_bad) begin
                            state_d = S_BREAK;
                        end else begin
                            state_d = S_IDLE;
                            push_d  = ~w_par_bad;
                        end
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        stop_bad_d = w_stop_bad;
                    end
                end
            end
            S_BREAK: begin
                if (w_line) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Synchroniser resets high so releasing reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= S_IDLE;
            div_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            stop_bad_q <= 1'b0;
            push_q     <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
`endif
        end else begin
            sync1_q    <= serial_in;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            stop_bad_q <= stop_bad_d;
            push_q     <= push_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
`endif
        end
    end

    assign w_valid   = (count_q != '0);
    assign w_full    = (count_q == COUNT_FULL);
    assign w_do_pop  = rd_en & w_valid;
    assign w_do_push = push_q & (~w_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ov_q     <= 1'b0;
        end else begin
            ov_q <= push_q & w_full & ~w_do_pop;
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign rd_data       = w_valid ? mem_q[rd_ptr_q] : '0;
    assign rd_valid      = w_valid;
    assign fifo_count    = count_q;
    assign busy          = (state_q != S_IDLE);
    assign framing_error = fe_q;
    assign overrun_error = ov_q;
    assign parity_error  = pe_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// tb_uart_rx_fifo: directed scoreboard bench for uart_rx_fifo at 16 clk/bit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Edge (counted from the start-bit drive) on which the last stop bit is sampled
    localparam int PUSH_CYC = CPB * (DW + 1 + PAR_BITS) + CPB / 2 + 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          serial_in;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW:0]   fifo_count;
    logic          busy;
    logic          framing_error;
    logic          overrun_error;
    logic          parity_error;

    int            total = 0;
    int            bad   = 0;
    int            fe_cnt = 0;
    int            ov_cnt = 0;
    int            pe_cnt = 0;
    logic [DW-1:0] sb[$];

    uart_rx_fifo #(
        .CLK_PER_BIT(CPB),
        .DATA_WIDTH (DW),
        .STOP_BITS  (1),
        .FIFO_DEPTH (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .fifo_count   (fifo_count),
        .busy         (busy),
        .framing_error(framing_error),
        .overrun_error(overrun_error),
        .parity_error (parity_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            fe_cnt += int'(framing_error);
            ov_cnt += int'(overrun_error);
            pe_cnt += int'(parity_error);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag);
        logic [DW-1:0] exp;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: observed=empty scoreboard expected=entry", tag);
        end else begin
            exp = sb.pop_front();
            check({tag, "_valid"}, 32'(rd_valid), 32'd1);
            check({tag, "_data"}, 32'(rd_data), 32'(exp));
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop_lvl, input logic par_ok,
                              input bit pop_at_push, output int rise_at);
        int            nbits;
        int            cyc;
        logic          lvl;
        logic          prev_v;
        logic [DW-1:0] head;
        nbits   = DW + PAR_BITS + 2;
        cyc     = 0;
        rise_at = -1;
        prev_v  = rd_valid;
        for (int b = 0; b < nbits; b++) begin
            if (b == 0) lvl = 1'b0;
            else if (b <= DW) lvl = d[b-1];
            else if (PAR_BITS == 1 && b == DW + 1) lvl = (^d) ^ ~par_ok;
            else lvl = stop_lvl;
            serial_in = lvl;
            for (int c = 0; c < CPB; c++) begin
                tick();
                cyc++;
                if (rise_at < 0 && rd_valid && !prev_v) rise_at = cyc;
                prev_v = rd_valid;
                if (pop_at_push && cyc == PUSH_CYC) begin
                    head = sb.pop_front();
                    check("push_pop_head", 32'(rd_data), 32'(head));
                    rd_en = 1'b1;
                end
                if (pop_at_push && cyc == PUSH_CYC + 1) rd_en = 1'b0;
            end
        end
    endtask

    initial begin
        int rise;
        int fe0, ov0, pe0;
        reset     = 1'b1;
        serial_in = 1'b1;
        rd_en     = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_errs", {29'd0, framing_error, overrun_error, parity_error}, 32'd0);
        reset = 1'b0;
        tick();

        // Single frame, latency and pop
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, rise);
        check("a5_rise_cycle", 32'(rise), 32'(PUSH_CYC + 1));
        check("a5_count", 32'(fifo_count), 32'd1);
        pop_check("a5_pop");
        check("a5_after_valid", 32'(rd_valid), 32'd0);
        check("a5_after_count", 32'(fifo_count), 32'd0);

        rd_en = 1'b1;
        repeat (2) tick();
        rd_en = 1'b0;
        check("underflow_count", 32'(fifo_count), 32'd0);

        // Short low glitch is a false start
        fe0 = fe_cnt;
        serial_in = 1'b0;
        repeat (4) tick();
        serial_in = 1'b1;
        tick();
        check("glitch_busy_hi", 32'(busy), 32'd1);
        repeat (10) tick();
        check("glitch_busy_lo", 32'(busy), 32'd0);
        check("glitch_count", 32'(fifo_count), 32'd0);
        check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);

        // Framing error followed by a held-low break
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, rise);
        repeat (100) tick();
        serial_in = 1'b1;
        repeat (4) tick();
        check("break_fe_once", 32'(fe_cnt - fe0), 32'd1);
        check("break_count", 32'(fifo_count), 32'd0);
        check("break_busy", 32'(busy), 32'd0);
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b1, 1'b0, rise);
        pop_check("after_break");

        // Seventeen back-to-back frames overflow a 16-deep FIFO
        ov0 = ov_cnt;
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i < DEPTH) sb.push_back(8'(8'h40 + i));
            send_frame(8'(8'h40 + i), 1'b1, 1'b1, 1'b0, rise);
        end
        check("ovr_count", 32'(fifo_count), 32'(DEPTH));
        check("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
        for (int i = 0; i < DEPTH; i++) pop_check("ovr_drain");
        check("ovr_empty", 32'(rd_valid), 32'd0);

        // Full FIFO with a pop in the push cycle
        for (int i = 0; i < DEPTH; i++) begin
            sb.push_back(8'(8'h80 + i));
            send_frame(8'(8'h80 + i), 1'b1, 1'b1, 1'b0, rise);
        end
        check("full_count", 32'(fifo_count), 32'(DEPTH));
        ov0 = ov_cnt;
        sb.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 1'b1, 1'b1, rise);
        check("pp_count", 32'(fifo_count), 32'(DEPTH));
        check("pp_no_ovr", 32'(ov_cnt - ov0), 32'd0);
        for (int i = 0; i < DEPTH; i++) pop_check("pp_drain");
        check("pp_empty", 32'(fifo_count), 32'd0);

`ifdef UART_RX_PARITY_EN
        pe0 = pe_cnt;
        sb.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, rise);
        check("par_ok_pe", 32'(pe_cnt - pe0), 32'd0);
        pop_check("par_ok");
        fe0 = fe_cnt;
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, rise);
        repeat (4) tick();
        check("par_bad_pe", 32'(pe_cnt - pe0), 32'd1);
        check("par_bad_fe", 32'(fe_cnt - fe0), 32'd0);
        check("par_bad_count", 32'(fifo_count), 32'd0);
`else
        pe0 = pe_cnt;
        check("no_par_pe", 32'(pe_cnt - pe0 + int'(parity_error)), 32'd0);
`endif

        // Reset in the middle of a data phase
        sb.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0, rise);
        check("pre_rst_count", 32'(fifo_count), 32'd1);
        serial_in = 1'b0;
        repeat (60) tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset     = 1'b1;
        serial_in = 1'b1;
        tick();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_valid", 32'(rd_valid), 32'd0);
        check("midrst_data", 32'(rd_data), 32'd0);
        sb.delete();
        reset = 1'b0;
        repeat (200) tick();
        check("postrst_count", 32'(fifo_count), 32'd0);
        check("postrst_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
